arriving_uranus: RTL and testbench
==================================

# arriving_uranus

Entry-direction sequencer for the Uranus airlock interlock: cycles an astronaut from outside the station, through the chamber, to the interior. Sits beside the departure controller in the interlock top level; the top level uses `busy` to keep the two sequencers mutually exclusive. Owns its own dwell timer, so no external counter is needed, and drives enable outputs that gate the outer and inner port actuators.

## Interface
- `EVAC_CYCLES`, default 2: evacuation dwell in clock cycles, minimum 1.
- `PRESS_CYCLES`, default 4: pressurization dwell in clock cycles, minimum 1.
- `CNT_W`, default 3: timer width; must satisfy 2^CNT_W ≥ max(EVAC_CYCLES, PRESS_CYCLES).
- `clock`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `outerPort`  in  1  outer port sensor; 1 = open.
- `innerPort`  in  1  inner port sensor; 1 = open.
- `arriving`  in  1  entry request from the exterior panel; level.
- `evac`  in  1  evacuate command; level.
- `pressurize`  in  1  pressurize command; level.
- `outerEnable`  out  1  outer port may open.
- `innerEnable`  out  1  inner port may open.
- `busy`  out  1  sequence in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse on sequence completion.
- `alarm`  out  1  sticky port-violation flag; see Configuration.

## Operation
- Moore FSM, 9 states, encoded in 4 bits. All transitions are evaluated on the clock edge:
  - IDLE: go to SEAL when `arriving & ~outerPort & ~innerPort`.
  - SEAL: go to EVACUATE when `evac & ~outerPort & ~innerPort`; clear the timer.
  - EVACUATE: go to OUTER_OPEN when timer = EVAC_CYCLES−1; otherwise increment the timer.
  - OUTER_OPEN: `outerEnable`=1; go to ENTERED when `outerPort & ~innerPort`.
  - ENTERED: `outerEnable`=1; go to PRESS_WAIT when `~outerPort & ~innerPort & ~arriving`.
  - PRESS_WAIT: go to PRESSURIZE when `pressurize & ~outerPort & ~innerPort`; clear the timer.
  - PRESSURIZE: go to INNER_OPEN when timer = PRESS_CYCLES−1; otherwise increment the timer.
  - INNER_OPEN: `innerEnable`=1; go to INNER_CLOSE when `innerPort & ~outerPort`.
  - INNER_CLOSE: `innerEnable`=1; go to IDLE when `~innerPort & ~outerPort`; set `done`.
- `outerEnable` and `innerEnable` are never both 1.
- `busy` = (state ≠ IDLE).
- While `busy`=1, `arriving` is ignored except in the ENTERED exit condition.
- A command (`evac`, `pressurize`) asserted with a port open is ignored. The FSM holds until the command is present with both ports closed.
- Timer is an unsigned CNT_W-bit up-counter; it is cleared only on entry to a dwell state and never wraps within a dwell.

## Timing
- Reset: state=IDLE, timer=0, and all outputs (`outerEnable`, `innerEnable`, `busy`, `done`, `alarm`) are 0 in the cycle after the `rst` edge.
- `rst` mid-sequence aborts immediately to IDLE with both enables low. No completion `done` pulse is generated.
- Enables and `busy` decode combinationally from the state register, so they are valid in the first cycle of the state.
- EVACUATE occupies exactly EVAC_CYCLES cycles; PRESSURIZE occupies exactly PRESS_CYCLES cycles.
- `done` is registered: high for exactly one cycle, the first cycle of IDLE after INNER_CLOSE.
- Minimum sequence latency is EVAC_CYCLES + PRESS_CYCLES + 7 cycles, from IDLE-exit edge to the `done` cycle, when every input is ready.
- A new request in the `done` cycle is accepted: IDLE → SEAL on that edge.

## Configuration
- Macro: `ARRIVING_URANUS_ALARM_EN`.
- Defined:
  - `alarm` sets on any cycle where `outerPort & ~outerEnable` or `innerPort & ~innerEnable`. This includes IDLE.
  - Once set, `alarm` holds until `rst`.
  - `alarm` is registered, so it rises one cycle after the violation.
  - `alarm` does not alter FSM transitions.
- Undefined: `alarm` is tied to 0 and no alarm logic is synthesized.

## Structure
- Shared package `uranus_pkg`: the state enum for this block (IDLE…INNER_CLOSE), port-sensor polarity constants, and default dwell constants (EVAC 2, PRESS 4). The departure controller uses the same package.
- One sub-module, `airlock_timer` (`clock`, `rst`, `clear`, `en`, `count[CNT_W-1:0]`). The sequencer drives `clear` on dwell entry and `en` during dwell.

## Test plan
- Nominal sequence, defaults, all inputs ready on time: `done` pulses exactly 13 cycles after the IDLE-exit edge. `outerEnable` is high 2+ cycles and `innerEnable` is high 2+ cycles, never overlapping.
- `evac`=1 while `innerPort`=1 in SEAL for 5 cycles: the FSM stays in SEAL, then proceeds within 1 cycle of `innerPort`=0.
- `rst` pulsed during PRESSURIZE with timer=2: the next cycle shows state IDLE, timer 0, all outputs 0, and no `done`.
- `arriving` held high through ENTERED: the FSM holds in ENTERED until `arriving`=0, with `outerEnable` held at 1.
- `EVAC_CYCLES`=1, `PRESS_CYCLES`=7: EVACUATE lasts 1 cycle, PRESSURIZE lasts 7 cycles, and the timer never exceeds 6.
- With `ARRIVING_URANUS_ALARM_EN` defined, `outerPort`=1 in IDLE for 1 cycle: `alarm` goes to 1 the next cycle and stays 1 until `rst`. With the macro undefined, `alarm` stays 0.

Source files
------------

// File: rtl/uranus_pkg.sv
// Shared definitions for the Uranus airlock interlock sequencers.
// Holds the entry-sequencer state encoding, port sensor polarity and default dwell lengths.
package uranus_pkg;

   typedef enum logic [3:0] {
      IDLE        = 4'd0,
      SEAL        = 4'd1,
      EVACUATE    = 4'd2,
      OUTER_OPEN  = 4'd3,
      ENTERED     = 4'd4,
      PRESS_WAIT  = 4'd5,
      PRESSURIZE  = 4'd6,
      INNER_OPEN  = 4'd7,
      INNER_CLOSE = 4'd8
   } arriving_state_t;

   localparam logic PORT_OPEN   = 1'b1;
   localparam logic PORT_CLOSED = 1'b0;

   localparam int DEFAULT_EVAC_CYCLES  = 2;
   localparam int DEFAULT_PRESS_CYCLES = 4;

endpackage

// File: rtl/airlock_timer.sv
// Dwell timer for the airlock sequencers: an unsigned up-counter with
// synchronous clear and count enable.
module airlock_timer #(
   parameter int CNT_W = 3
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   // Clear wins over enable so a dwell always starts from zero.
   always_ff @(posedge clock) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/arriving_uranus.sv
// Entry-direction airlock sequencer: outside -> chamber -> interior.
// Optional sticky port-violation alarm is built only when ARRIVING_URANUS_ALARM_EN is defined.
module arriving_uranus
   import uranus_pkg::*;
#(
   parameter int EVAC_CYCLES  = DEFAULT_EVAC_CYCLES,
   parameter int PRESS_CYCLES = DEFAULT_PRESS_CYCLES,
   parameter int CNT_W        = 3
) (
   input  logic clock,
   input  logic rst,
   input  logic outerPort,
   input  logic innerPort,
   input  logic arriving,
   input  logic evac,
   input  logic pressurize,
   output logic outerEnable,
   output logic innerEnable,
   output logic busy,
   output logic done,
   output logic alarm
);

   localparam logic [CNT_W-1:0] EVAC_LAST  = CNT_W'(EVAC_CYCLES - 1);
   localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CYCLES - 1);

   arriving_state_t  state;
   logic [CNT_W-1:0] count;
   logic             ports_closed;
   logic             timer_clear;
   logic             timer_en;

   assign ports_closed = (outerPort == PORT_CLOSED) && (innerPort == PORT_CLOSED);

   // The timer is cleared on the edge that enters a dwell and counts until the last dwell cycle.
   always_comb begin
      timer_clear = 1'b0;
      timer_en    = 1'b0;
      case (state)
         SEAL:       timer_clear = evac & ports_closed;
         PRESS_WAIT: timer_clear = pressurize & ports_closed;
         EVACUATE:   timer_en    = (count != EVAC_LAST);
         PRESSURIZE: timer_en    = (count != PRESS_LAST);
         default: ;
      endcase
   end

   airlock_timer #(.CNT_W(CNT_W)) u_timer (
      .clock (clock),
      .rst   (rst),
      .clear (timer_clear),
      .en    (timer_en),
      .count (count)
   );

   always_ff @(posedge clock) begin
      if (rst) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE:        if (arriving && ports_closed) state <= SEAL;
            SEAL:        if (evac && ports_closed) state <= EVACUATE;
            EVACUATE:    if (count == EVAC_LAST) state <= OUTER_OPEN;
            OUTER_OPEN:  if (outerPort == PORT_OPEN && innerPort == PORT_CLOSED) state <= ENTERED;
            ENTERED:     if (ports_closed && !arriving) state <= PRESS_WAIT;
            PRESS_WAIT:  if (pressurize && ports_closed) state <= PRESSURIZE;
            PRESSURIZE:  if (count == PRESS_LAST) state <= INNER_OPEN;
            INNER_OPEN:  if (innerPort == PORT_OPEN && outerPort == PORT_CLOSED) state <= INNER_CLOSE;
            INNER_CLOSE: begin
               if (ports_closed) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default:     state <= IDLE;
         endcase
      end
   end

   assign outerEnable = (state == OUTER_OPEN) || (state == ENTERED);
   assign innerEnable = (state == INNER_OPEN) || (state == INNER_CLOSE);
   assign busy        = (state != IDLE);

`ifdef ARRIVING_URANUS_ALARM_EN
   logic alarm_q;

   // Sticky: any port open without its enable latches the alarm until reset.
   always_ff @(posedge clock) begin
      if (rst) begin
         alarm_q <= 1'b0;
      end else if ((outerPort == PORT_OPEN && !outerEnable) ||
                   (innerPort == PORT_OPEN && !innerEnable)) begin
         alarm_q <= 1'b1;
      end
   end

   assign alarm = alarm_q;
`else
   assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_arriving_uranus.sv
// Directed self-checking bench for arriving_uranus (default dwells plus an EVAC=1/PRESS=7 instance).
// Alarm expectations follow ARRIVING_URANUS_ALARM_EN.
module tb_arriving_uranus;
   import uranus_pkg::*;

`ifdef ARRIVING_URANUS_ALARM_EN
   localparam logic ALARM_ON = 1'b1;
`else
   localparam logic ALARM_ON = 1'b0;
`endif

   logic clock = 1'b0;
   logic rst   = 1'b0;
   logic outer_port, inner_port, arriving, evac, pressurize;
   logic outer_en, inner_en, busy, done, alarm;
   logic s_outer_port, s_inner_port, s_arriving, s_evac, s_pressurize;
   logic s_outer_en, s_inner_en, s_busy, s_done, s_alarm;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   arriving_uranus dut (
      .clock(clock), .rst(rst),
      .outerPort(outer_port), .innerPort(inner_port), .arriving(arriving),
      .evac(evac), .pressurize(pressurize),
      .outerEnable(outer_en), .innerEnable(inner_en), .busy(busy),
      .done(done), .alarm(alarm)
   );

   arriving_uranus #(.EVAC_CYCLES(1), .PRESS_CYCLES(7), .CNT_W(3)) dut_short (
      .clock(clock), .rst(rst),
      .outerPort(s_outer_port), .innerPort(s_inner_port), .arriving(s_arriving),
      .evac(s_evac), .pressurize(s_pressurize),
      .outerEnable(s_outer_en), .innerEnable(s_inner_en), .busy(s_busy),
      .done(s_done), .alarm(s_alarm)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      {outer_port, inner_port, arriving, evac, pressurize} = '0;
      {s_outer_port, s_inner_port, s_arriving, s_evac, s_pressurize} = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Input schedule for a ready-on-time entry, applied after observing cycle k.
   task automatic drive_nominal(input int k);
      case (k)
         0:  arriving   = 1'b0;
         3:  outer_port = 1'b1;
         4:  outer_port = 1'b0;
         10: inner_port = 1'b1;
         11: inner_port = 1'b0;
         default: ;
      endcase
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (dut.state !== IDLE) begin
         errors++; $display("[TB] FAIL reset_state: got %0d expected %0d", int'(dut.state), int'(IDLE));
      end
      checks++;
      if (dut.count !== 3'd0) begin
         errors++; $display("[TB] FAIL reset_timer: got %0d expected 0", dut.count);
      end
      checks++;
      if ({outer_en, inner_en, busy, done, alarm} !== 5'b00000) begin
         errors++; $display("[TB] FAIL reset_outputs: got %b expected 00000", {outer_en, inner_en, busy, done, alarm});
      end
   endtask

   task automatic test_nominal();
      arriving_state_t exp_state [14] = '{SEAL, EVACUATE, EVACUATE, OUTER_OPEN, ENTERED, PRESS_WAIT,
                                          PRESSURIZE, PRESSURIZE, PRESSURIZE, PRESSURIZE,
                                          INNER_OPEN, INNER_CLOSE, IDLE, IDLE};
      logic [3:0] exp_out;
      do_reset();
      arriving = 1'b1; evac = 1'b1; pressurize = 1'b1;
      for (int k = 0; k < 14; k++) begin
         step();
         exp_out[3] = (k == 3 || k == 4);
         exp_out[2] = (k == 10 || k == 11);
         exp_out[1] = (k <= 11);
         exp_out[0] = (k == 12);
         checks++;
         if (dut.state !== exp_state[k]) begin
            errors++; $display("[TB] FAIL nominal_state[%0d]: got %0d expected %0d", k, int'(dut.state), int'(exp_state[k]));
         end
         checks++;
         if ({outer_en, inner_en, busy, done} !== exp_out) begin
            errors++; $display("[TB] FAIL nominal_outputs[%0d]: got %b expected %b", k, {outer_en, inner_en, busy, done}, exp_out);
         end
         drive_nominal(k);
      end
      checks++;
      if (alarm !== 1'b0) begin
         errors++; $display("[TB] FAIL nominal_alarm: got %b expected 0", alarm);
      end
   endtask

   task automatic test_evac_blocked();
      do_reset();
      arriving = 1'b1;
      step();
      arriving = 1'b0; evac = 1'b1; inner_port = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if (dut.state !== SEAL) begin
            errors++; $display("[TB] FAIL evac_blocked_hold[%0d]: got %0d expected %0d", k, int'(dut.state), int'(SEAL));
         end
      end
      inner_port = 1'b0;
      step();
      checks++;
      if (dut.state !== EVACUATE) begin
         errors++; $display("[TB] FAIL evac_blocked_release: got %0d expected %0d", int'(dut.state), int'(EVACUATE));
      end
   endtask

   task automatic test_reset_abort();
      do_reset();
      arriving = 1'b1; evac = 1'b1; pressurize = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         step();
         drive_nominal(k);
      end
      checks++;
      if (dut.state !== PRESSURIZE || dut.count !== 3'd2) begin
         errors++; $display("[TB] FAIL abort_setup: got state %0d timer %0d expected %0d timer 2", int'(dut.state), dut.count, int'(PRESSURIZE));
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (dut.state !== IDLE || dut.count !== 3'd0) begin
         errors++; $display("[TB] FAIL abort_state: got state %0d timer %0d expected %0d timer 0", int'(dut.state), dut.count, int'(IDLE));
      end
      checks++;
      if ({outer_en, inner_en, busy, done, alarm} !== 5'b00000) begin
         errors++; $display("[TB] FAIL abort_outputs: got %b expected 00000", {outer_en, inner_en, busy, done, alarm});
      end
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_no_done[%0d]: got done %b busy %b expected 0 0", k, done, busy);
         end
      end
   endtask

   task automatic test_hold_entered();
      do_reset();
      arriving = 1'b1; evac = 1'b1; pressurize = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         step();
         if (k == 3) outer_port = 1'b1;
         if (k == 4) outer_port = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
         step();
         checks++;
         if (dut.state !== ENTERED || outer_en !== 1'b1) begin
            errors++; $display("[TB] FAIL hold_entered[%0d]: got state %0d outerEnable %b expected %0d 1", k, int'(dut.state), outer_en, int'(ENTERED));
         end
      end
      arriving = 1'b0;
      step();
      checks++;
      if (dut.state !== PRESS_WAIT || outer_en !== 1'b0) begin
         errors++; $display("[TB] FAIL hold_entered_exit: got state %0d outerEnable %b expected %0d 0", int'(dut.state), outer_en, int'(PRESS_WAIT));
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      arriving = 1'b1; evac = 1'b1; pressurize = 1'b1;
      for (int k = 0; k <= 12; k++) begin
         step();
         drive_nominal(k);
      end
      checks++;
      if (dut.state !== IDLE || done !== 1'b1) begin
         errors++; $display("[TB] FAIL b2b_done: got state %0d done %b expected %0d 1", int'(dut.state), done, int'(IDLE));
      end
      arriving = 1'b1;
      step();
      checks++;
      if (dut.state !== SEAL || done !== 1'b0) begin
         errors++; $display("[TB] FAIL b2b_accept: got state %0d done %b expected %0d 0", int'(dut.state), done, int'(SEAL));
      end
      arriving = 1'b0;
   endtask

   task automatic test_short_dwell();
      arriving_state_t exp_state [13] = '{SEAL, EVACUATE, OUTER_OPEN, ENTERED, PRESS_WAIT,
                                          PRESSURIZE, PRESSURIZE, PRESSURIZE, PRESSURIZE,
                                          PRESSURIZE, PRESSURIZE, PRESSURIZE, INNER_OPEN};
      int max_count = 0;
      do_reset();
      s_arriving = 1'b1; s_evac = 1'b1; s_pressurize = 1'b1;
      for (int k = 0; k < 13; k++) begin
         step();
         checks++;
         if (dut_short.state !== exp_state[k]) begin
            errors++; $display("[TB] FAIL short_state[%0d]: got %0d expected %0d", k, int'(dut_short.state), int'(exp_state[k]));
         end
         if (int'(dut_short.count) > max_count) max_count = int'(dut_short.count);
         if (k == 11) begin
            checks++;
            if (dut_short.count !== 3'd6) begin
               errors++; $display("[TB] FAIL short_last_count: got %0d expected 6", dut_short.count);
            end
         end
         case (k)
            0: s_arriving   = 1'b0;
            2: s_outer_port = 1'b1;
            3: s_outer_port = 1'b0;
            default: ;
         endcase
      end
      checks++;
      if (max_count > 6) begin
         errors++; $display("[TB] FAIL short_timer_max: got %0d expected at most 6", max_count);
      end
      s_inner_port = 1'b1;
      step();
      s_inner_port = 1'b0;
      step();
      checks++;
      if (s_done !== 1'b1 || s_busy !== 1'b0) begin
         errors++; $display("[TB] FAIL short_done: got done %b busy %b expected 1 0", s_done, s_busy);
      end
   endtask

   task automatic test_alarm();
      do_reset();
      outer_port = 1'b1;
      step();
      outer_port = 1'b0;
      step();
      checks++;
      if (alarm !== ALARM_ON) begin
         errors++; $display("[TB] FAIL alarm_rise: got %b expected %b", alarm, ALARM_ON);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (alarm !== ALARM_ON || dut.state !== IDLE) begin
            errors++; $display("[TB] FAIL alarm_hold[%0d]: got alarm %b state %0d expected %b %0d", k, alarm, int'(dut.state), ALARM_ON, int'(IDLE));
         end
      end
      do_reset();
      checks++;
      if (alarm !== 1'b0) begin
         errors++; $display("[TB] FAIL alarm_clear: got %b expected 0", alarm);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_evac_blocked();
      test_reset_abort();
      test_hold_entered();
      test_back_to_back();
      test_short_dwell();
      test_alarm();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
